// File: rtl/sdram_rd_pixel_fetch_if.sv
// Pixel stream from the SDRAM read front end to the LCD resize path.
// The master drives pixels and markers; the slave drives pix_ready.
interface sdram_rd_pixel_fetch_if #(
  parameter int unsigned DATA_W = 16
) ();
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              pix_ready;
  logic              pix_sof;
  logic              pix_eol;

  modport master (
    output pix_data, pix_valid, pix_sof, pix_eol,
    input  pix_ready
  );

  modport slave (
    input  pix_data, pix_valid, pix_sof, pix_eol,
    output pix_ready
  );
endinterface

// File: rtl/sdram_rd_pixel_fetch.sv
// Frame-read front end: reloads the SDRAM read port, prefills, pops the read
// FIFO and re-times its 1-clock latency through a 2-entry FWFT pixel buffer.
module sdram_rd_pixel_fetch #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned H_ACT       = 800,
  parameter int unsigned V_ACT       = 480,
  parameter int unsigned LOAD_CYC    = 4,
  parameter int unsigned PREFILL_CYC = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sdram_init_done,
  input  logic                   frame_start,
  output logic                   rd_load,
  output logic                   rd_en,
  input  logic [DATA_W-1:0]      rd_data,
  output logic                   sdram_read_valid,
  output logic                   pingpong,
  sdram_rd_pixel_fetch_if.master pix,
  output logic                   frame_err
);
  localparam int unsigned   HW           = $clog2(H_ACT + 1);
  localparam int unsigned   VW           = $clog2(V_ACT + 1);
  localparam logic [HW-1:0] H_LAST       = HW'(H_ACT - 1);
  localparam logic [VW-1:0] V_LAST       = VW'(V_ACT - 1);
  localparam logic [31:0]   TOTAL        = 32'(H_ACT * V_ACT);
  localparam logic [15:0]   LOAD_LAST    = 16'(LOAD_CYC - 1);
  localparam logic [15:0]   PREFILL_LAST = 16'(PREFILL_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_PREFILL, S_STREAM, S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic              init_meta_q, init_sync_q;
  logic [15:0]       cnt_q, cnt_d;
  logic [31:0]       issued_q, issued_d;
  logic [HW-1:0]     h_cnt_q, h_cnt_d;
  logic [VW-1:0]     v_cnt_q, v_cnt_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [DATA_W-1:0] buf_d [2];
  logic              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]        occ_q, occ_d;
  logic              inflight_q, inflight_d;
  logic              rd_load_q, rd_load_d;
  logic              srv_q, srv_d;
  logic              pingpong_q, pingpong_d;
  logic              frame_err_q, frame_err_d;
  logic              pix_valid_c, push, pop, last_pix;
  logic [2:0]        pipe_cnt;

  always_comb begin
    pix_valid_c = (occ_q != 2'd0);
    pop         = pix_valid_c && pix.pix_ready;
    push        = (state_q == S_STREAM) && inflight_q;
    last_pix    = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    // Occupancy is counted after this clock's pop, so a word leaving the
    // buffer frees its slot for the same-clock rd_en (1 pixel/clock).
    pipe_cnt    = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
    rd_en       = (state_q == S_STREAM) && (pipe_cnt < 3'd2) && (issued_q < TOTAL);

    state_d     = state_q;
    cnt_d       = cnt_q;
    issued_d    = issued_q + 32'(rd_en);
    h_cnt_d     = h_cnt_q;
    v_cnt_d     = v_cnt_q;
    buf_d       = buf_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inflight_d  = rd_en;
    occ_d       = occ_q + {1'b0, push} - {1'b0, pop};
    pingpong_d  = pingpong_q;
    frame_err_d = 1'b0;

    if (push) begin
      buf_d[wr_ptr_q] = rd_data;
      wr_ptr_d        = ~wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = ~rd_ptr_q;
      if (h_cnt_q == H_LAST) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
      end else begin
        h_cnt_d = h_cnt_q + HW'(1);
      end
    end

    unique case (state_q)
      S_IDLE: if (frame_start && init_sync_q) state_d = S_LOAD;
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) state_d = S_PREFILL;
        else                    cnt_d   = cnt_q + 16'd1;
      end
      S_PREFILL: begin
        if (frame_start) begin
          state_d     = S_LOAD;
          frame_err_d = 1'b1;
        end else if (cnt_q == PREFILL_LAST) begin
          state_d = S_STREAM;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_STREAM: begin
        if (frame_start) begin
          state_d     = S_LOAD;
          frame_err_d = 1'b1;
        end else if (pop && last_pix) begin
          state_d    = S_DONE;
          pingpong_d = ~pingpong_q;
        end
      end
      S_DONE:  if (frame_start) state_d = S_LOAD;
      default: state_d = S_IDLE;
    endcase

    if (!init_sync_q) begin
      state_d     = S_IDLE;
      frame_err_d = 1'b0;
    end

    if (state_d != state_q) cnt_d = '0;
    if (state_d == S_LOAD) begin
      issued_d = '0;
      h_cnt_d  = '0;
      v_cnt_d  = '0;
    end
    // Anything still buffered or in flight is dropped when streaming ends.
    if (state_d != S_STREAM) begin
      occ_d      = '0;
      wr_ptr_d   = 1'b0;
      rd_ptr_d   = 1'b0;
      inflight_d = 1'b0;
    end

    rd_load_d = (state_d == S_LOAD);
    srv_d     = (state_d == S_PREFILL) || (state_d == S_STREAM) || (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      init_meta_q <= 1'b0;
      init_sync_q <= 1'b0;
      cnt_q       <= '0;
      issued_q    <= '0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      buf_q[0]    <= '0;
      buf_q[1]    <= '0;
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      occ_q       <= '0;
      inflight_q  <= 1'b0;
      rd_load_q   <= 1'b0;
      srv_q       <= 1'b0;
      pingpong_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_meta_q <= sdram_init_done;
      init_sync_q <= init_meta_q;
      cnt_q       <= cnt_d;
      issued_q    <= issued_d;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      buf_q       <= buf_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      occ_q       <= occ_d;
      inflight_q  <= inflight_d;
      rd_load_q   <= rd_load_d;
      srv_q       <= srv_d;
      pingpong_q  <= pingpong_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push && !pop) assert (occ_q != 2'd2);
  end

  assign rd_load          = rd_load_q;
  assign sdram_read_valid = srv_q;
  assign pingpong         = pingpong_q;
  assign frame_err        = frame_err_q;
  assign pix.pix_valid    = pix_valid_c;
  assign pix.pix_data     = buf_q[rd_ptr_q];
  assign pix.pix_sof      = pix_valid_c && (h_cnt_q == '0) && (v_cnt_q == '0);
  assign pix.pix_eol      = pix_valid_c && (h_cnt_q == H_LAST);
endmodule

// File: tb/tb_sdram_rd_pixel_fetch.sv
// Directed bench for sdram_rd_pixel_fetch with a small 4x2 frame and a
// read-FIFO model returning incrementing words after each rd_load.
module tb_sdram_rd_pixel_fetch;
  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          fs = 1'b0;
  logic          rd_load, rd_en, srv, pingpong, frame_err;
  logic [DW-1:0] rd_data = '0;
  int unsigned   next_word = 0;

  sdram_rd_pixel_fetch_if #(.DATA_W(DW)) pif ();

  sdram_rd_pixel_fetch #(
    .DATA_W(DW), .H_ACT(4), .V_ACT(2), .LOAD_CYC(4), .PREFILL_CYC(8)
  ) dut (
    .clk(clk), .rst(rst), .sdram_init_done(init_done), .frame_start(fs),
    .rd_load(rd_load), .rd_en(rd_en), .rd_data(rd_data),
    .sdram_read_valid(srv), .pingpong(pingpong), .pix(pif), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rd_load) next_word <= 0;
    else if (rd_en) begin
      rd_data   <= DW'(next_word);
      next_word <= next_word + 1;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  int          cyc = 0, rd_cnt = 0, load_cnt = 0, err_cnt = 0, issued = 0, accepted = 0;
  int          t_load = 0, t_rden = 0, t_pv = 0, t_acc0 = 0, t_accn = 0;
  bit          seen_load = 0, seen_rden = 0, seen_pv = 0;
  logic [DW-1:0] acc_data[$];
  bit          acc_sof[$], acc_eol[$];
  bit          prev_stall = 0, prev_sof = 0, prev_eol = 0;
  logic [DW-1:0] prev_data = '0;

  always @(negedge clk) begin
    int pop_i;
    cyc++;
    if (rst) begin
      prev_stall = 0;
      issued     = 0;
      accepted   = 0;
    end else begin
      if (rd_load) begin
        issued   = 0;
        accepted = 0;
        load_cnt++;
        if (!seen_load) begin seen_load = 1; t_load = cyc; end
      end
      pop_i = (pif.pix_valid && pif.pix_ready) ? 1 : 0;
      if (prev_stall) begin
        check_eq("stall_valid", pif.pix_valid, 1);
        check_eq("stall_data", pif.pix_data, prev_data);
        check_eq("stall_sof", pif.pix_sof, prev_sof);
        check_eq("stall_eol", pif.pix_eol, prev_eol);
      end
      if (rd_en) begin
        check_eq("rd_en_room", ((issued - accepted - pop_i) < 2) ? 1 : 0, 1);
        issued++;
        rd_cnt++;
        if (!seen_rden) begin seen_rden = 1; t_rden = cyc; end
      end
      if (pif.pix_valid && !seen_pv) begin seen_pv = 1; t_pv = cyc; end
      if (pop_i == 1) begin
        if (acc_data.size() == 0) t_acc0 = cyc;
        t_accn = cyc;
        acc_data.push_back(pif.pix_data);
        acc_sof.push_back(pif.pix_sof);
        acc_eol.push_back(pif.pix_eol);
        accepted++;
      end
      if (frame_err) err_cnt++;
      prev_stall = pif.pix_valid && !pif.pix_ready;
      prev_data  = pif.pix_data;
      prev_sof   = pif.pix_sof;
      prev_eol   = pif.pix_eol;
    end
  end

  int         ready_mode = 0;
  int         pat_i = 0;
  logic [3:0] ready_pat = 4'b1001;

  task automatic step();
    @(posedge clk);
    #1;
    pat_i++;
    case (ready_mode)
      1:       pif.pix_ready = ready_pat[pat_i % 4];
      2:       pif.pix_ready = 1'b0;
      default: pif.pix_ready = 1'b1;
    endcase
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic pulse_fs();
    fs = 1'b1;
    step();
    fs = 1'b0;
  endtask

  task automatic clear_log();
    rd_cnt = 0; load_cnt = 0; err_cnt = 0;
    seen_load = 0; seen_rden = 0; seen_pv = 0;
    acc_data.delete(); acc_sof.delete(); acc_eol.delete();
  endtask

  task automatic wait_accepts(input int n);
    int k = 0;
    while (acc_data.size() < n && k < 300) begin step(); k++; end
    check_eq("accept_timeout", (acc_data.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic wait_rden(input int n);
    int k = 0;
    while (rd_cnt < n && k < 300) begin step(); k++; end
    check_eq("rden_timeout", (rd_cnt >= n) ? 1 : 0, 1);
  endtask

  // Expected stream: words restart at 0 every frame of 8; sof on word 0, eol on 3 and 7.
  task automatic check_stream(input string tag, input int n);
    int sof_total = 0;
    check_eq({tag, "_count"}, acc_data.size(), n);
    for (int i = 0; i < n && i < acc_data.size(); i++) begin
      check_eq({tag, "_data"}, acc_data[i], i % 8);
      check_eq({tag, "_sof"}, acc_sof[i], (i % 8 == 0) ? 1 : 0);
      check_eq({tag, "_eol"}, acc_eol[i], (i % 4 == 3) ? 1 : 0);
      sof_total += acc_sof[i];
    end
    check_eq({tag, "_sof_total"}, sof_total, n / 8);
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rd_load"}, rd_load, 0);
    check_eq({tag, "_rd_en"}, rd_en, 0);
    check_eq({tag, "_srv"}, srv, 0);
    check_eq({tag, "_pingpong"}, pingpong, 0);
    check_eq({tag, "_frame_err"}, frame_err, 0);
    check_eq({tag, "_pix_valid"}, pif.pix_valid, 0);
    check_eq({tag, "_pix_data"}, pif.pix_data, 0);
    check_eq({tag, "_pix_sof"}, pif.pix_sof, 0);
    check_eq({tag, "_pix_eol"}, pif.pix_eol, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pif.pix_ready = 1'b1;

    // Reset state
    steps(3);
    check_all_zero("reset");
    init_done = 1'b1;
    rst       = 1'b0;
    steps(3);

    // Frame 1: ready held high
    clear_log();
    pulse_fs();
    check_eq("t1_pingpong_before", pingpong, 0);
    wait_accepts(8);
    steps(2);
    check_stream("t1", 8);
    check_eq("t1_load_cycles", load_cnt, 4);
    check_eq("t1_first_rden", t_rden - t_load, 12);
    check_eq("t1_first_valid", t_pv - t_rden, 2);
    check_eq("t1_throughput", t_accn - t_acc0, 7);
    check_eq("t1_rd_en_total", rd_cnt, 8);
    check_eq("t1_pingpong_after", pingpong, 1);
    check_eq("t1_srv_done", srv, 1);

    // Frame 2: ready toggling 1,0,0,1
    ready_mode = 1;
    clear_log();
    pulse_fs();
    wait_accepts(8);
    steps(2);
    check_stream("t2", 8);
    check_eq("t2_rd_en_total", rd_cnt, 8);
    check_eq("t2_pingpong", pingpong, 0);
    ready_mode = 0;
    step();

    // Abort at pixel 5
    clear_log();
    pulse_fs();
    wait_accepts(5);
    pulse_fs();
    check_eq("t3_frame_err", frame_err, 1);
    check_eq("t3_rd_load", rd_load, 1);
    check_eq("t3_valid_dropped", pif.pix_valid, 0);
    check_eq("t3_pingpong_kept", pingpong, 0);
    clear_log();
    wait_accepts(8);
    steps(2);
    check_stream("t3", 8);
    check_eq("t3_err_pulses", err_cnt, 1);
    check_eq("t3_load_cycles", load_cnt, 4);
    check_eq("t3_rd_en_total", rd_cnt, 8);
    check_eq("t3_pingpong_after", pingpong, 1);

    // init_done low: frame_start ignored
    init_done = 1'b0;
    steps(3);
    check_eq("t4_srv_idle", srv, 0);
    clear_log();
    pulse_fs();
    steps(20);
    check_eq("t4_no_load", load_cnt, 0);
    check_eq("t4_srv_still0", srv, 0);
    check_eq("t4_no_valid", seen_pv, 0);

    // init_done dropped mid-stream
    init_done = 1'b1;
    steps(3);
    clear_log();
    pulse_fs();
    wait_accepts(3);
    init_done = 1'b0;
    steps(2);
    check_eq("t4_srv_before_loss", srv, 1);
    step();
    check_eq("t4_srv_lost", srv, 0);
    check_eq("t4_rd_en_lost", rd_en, 0);
    check_eq("t4_valid_lost", pif.pix_valid, 0);
    check_eq("t4_no_frame_err", err_cnt, 0);
    check_eq("t4_pingpong_kept", pingpong, 1);

    // Reset mid-stream with two words buffered
    init_done  = 1'b1;
    steps(3);
    ready_mode = 2;
    clear_log();
    pulse_fs();
    wait_rden(2);
    steps(3);
    check_eq("t5_rd_en_capped", rd_cnt, 2);
    check_eq("t5_valid_buffered", pif.pix_valid, 1);
    check_eq("t5_head_word", pif.pix_data, 0);
    rst = 1'b1;
    step();
    check_all_zero("t5_reset");
    rst        = 1'b0;
    ready_mode = 0;
    clear_log();
    steps(30);
    check_eq("t5_no_valid", acc_data.size(), 0);
    check_eq("t5_no_rden", rd_cnt, 0);
    check_eq("t5_no_load", load_cnt, 0);
    pulse_fs();
    wait_accepts(8);
    steps(2);
    check_stream("t5", 8);
    check_eq("t5_pingpong", pingpong, 1);

    // Two consecutive frames from reset
    rst = 1'b1;
    steps(2);
    rst = 1'b0;
    steps(3);
    clear_log();
    pulse_fs();
    wait_accepts(8);
    check_eq("t6_pingpong_f1", pingpong, 1);
    pulse_fs();
    wait_accepts(16);
    steps(2);
    check_stream("t6", 16);
    check_eq("t6_pingpong_f2", pingpong, 0);
    check_eq("t6_rd_en_total", rd_cnt, 16);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/sdram_rd_pixel_fetch.md
Name: sdram_rd_pixel_fetch

Overview:
- Frame-read front end on the read-FIFO side of the SDRAM controller top.
- Per frame: issues the read-port reload (rd_load), waits for the read FIFO to prefill, then pops the FIFO with rd_en.
- Absorbs the one-cycle FIFO read latency in a 2-entry buffer and presents a valid/ready pixel stream with start-of-frame and end-of-line markers to the LCD resize path.
- Owns the pingpong bank select and the sdram_read_valid enable.

Parameters:
- DATA_W, 16: pixel/FIFO word width; must equal `FIFO_WIDTH.
- H_ACT, 800: pixels per line.
- V_ACT, 480: lines per frame.
- LOAD_CYC, 4: rd_load pulse width in clocks (1..15).
- PREFILL_CYC, 256: clocks waited after rd_load before the first rd_en (1..65535).

Ports:
- clk  in  1  read-side clock; same clock as the read FIFO's rd_clk.
- rst  in  1  synchronous active-high reset.
- sdram_init_done  in  1  controller init flag from the ref_clk domain; double-flop synchronised internally.
- frame_start  in  1  one-cycle pulse from the LCD timing generator.
- rd_load  out  1  read-port reload: resets the read address and flushes the read FIFO.
- rd_en  out  1  read-FIFO pop.
- rd_data  in  DATA_W  read-FIFO data, valid exactly 1 clock after rd_en.
- sdram_read_valid  out  1  enables SDRAM read refill.
- pingpong  out  1  bank select for the current read frame.
- pix_data  out  DATA_W  output pixel.
- pix_valid  out  1  pix_data valid.
- pix_ready  in  1  downstream accept.
- pix_sof  out  1  qualifies the first pixel of a frame.
- pix_eol  out  1  qualifies the last pixel of a line.
- frame_err  out  1  one-cycle pulse when a frame is aborted.

Behaviour:
- Reset: all outputs 0; state IDLE; counters, buffer and in-flight flag cleared. Reset mid-frame discards buffered data with no further rd_en.
- Handshake: a pixel transfers on pix_valid & pix_ready. pix_data, pix_sof and pix_eol hold stable while pix_valid=1 and pix_ready=0.
- State machine:
  - IDLE: wait for synchronised init_done=1 and frame_start -> LOAD. frame_start while init_done=0 is ignored.
  - LOAD: rd_load=1 for exactly LOAD_CYC clocks; buffer and counters cleared -> PREFILL.
  - PREFILL: sdram_read_valid=1; count PREFILL_CYC clocks -> STREAM.
  - STREAM:
    - rd_en=1 when buffer occupancy + in-flight < 2 and issued < H_ACT*V_ACT.
    - The word returned one clock after rd_en is written to the buffer.
    - Exit -> DONE when H_ACT*V_ACT pixels have been accepted downstream.
  - DONE: pingpong toggles on the DONE entry clock; sdram_read_valid stays 1; next frame_start -> LOAD.
- sdram_read_valid is 0 in IDLE and LOAD, 1 in PREFILL, STREAM and DONE.
- Abort: frame_start in PREFILL or STREAM -> frame_err pulse on the following clock, then LOAD. In-flight/buffered words are dropped and pingpong is not toggled. frame_start in LOAD is ignored.
- Loss of synchronised init_done in any state -> IDLE next clock (no frame_err).
- Buffer: 2-entry FIFO, first-word-fall-through to pix_*. Simultaneous write and read in the same clock is legal at occupancy 1 or 2. Overflow is impossible by the rd_en rule; a violation is an assertion failure.
- Counters:
  - h_cnt in 0..H_ACT-1 and v_cnt in 0..V_ACT-1, advanced on output handshake; h_cnt wraps to 0 and increments v_cnt.
  - pix_sof = (h_cnt==0 && v_cnt==0) with pix_valid.
  - pix_eol = (h_cnt==H_ACT-1) with pix_valid.
  - Issue counter is 32-bit; rd_en count per frame is exactly H_ACT*V_ACT.
- Latency: first rd_en at clock LOAD_CYC+PREFILL_CYC after frame_start acceptance. pix_valid rises 2 clocks after the first rd_en (1 FIFO latency + 1 buffer register).
- Throughput: 1 pixel/clock sustained with pix_ready held high.

Test Plan:
- Reset, init_done=1, frame_start; H_ACT=4, V_ACT=2, LOAD_CYC=4, PREFILL_CYC=8; pix_ready=1; FIFO model returns incrementing words 0..7 -> rd_load high for 4 clocks; first rd_en 12 clocks later; exactly 8 rd_en; pix_data 0..7 contiguous; pix_sof on word 0; pix_eol on words 3 and 7; pingpong 0->1 at DONE.
- Same setup with pix_ready toggling 1,0,0,1 -> no word lost or duplicated; outputs stable while stalled; rd_en never issued when occupancy+in-flight=2.
- frame_start at pixel 5 of the first frame -> frame_err single pulse; rd_load reissued; pingpong unchanged; new frame restarts at word 0 with pix_sof.
- frame_start with init_done=0 -> stays IDLE, no rd_load. Dropping init_done mid-STREAM -> IDLE next clock; rd_en and sdram_read_valid go to 0.
- rst asserted mid-STREAM with 2 words buffered -> all outputs 0 the next clock; no pix_valid until a new frame_start and prefill complete.
- Two consecutive full frames -> pingpong toggles 0->1->0; 16 words total in order; pix_sof exactly twice.
